// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-counter monitor: the eight legal 4-bit
// Johnson codes, the monitor FSM states, and the code-to-phase decode function.
package johnson_pkg;

    // Legal Johnson codes in sequence order; the index is the phase.
    localparam logic [3:0] JC_0 = 4'b0000;
    localparam logic [3:0] JC_1 = 4'b1000;
    localparam logic [3:0] JC_2 = 4'b1100;
    localparam logic [3:0] JC_3 = 4'b1110;
    localparam logic [3:0] JC_4 = 4'b1111;
    localparam logic [3:0] JC_5 = 4'b0111;
    localparam logic [3:0] JC_6 = 4'b0011;
    localparam logic [3:0] JC_7 = 4'b0001;

    // Phase at which the next legal step wraps back to phase 0.
    localparam logic [2:0] PHASE_LAST = 3'd7;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] phase;
    } jc_dec_t;

    // Maps a 4-bit code to its phase; the eight non-Johnson codes are flagged illegal.
    function automatic jc_dec_t jc_to_phase(input logic [3:0] code);
        jc_dec_t d;
        // NOTE: every field gets a value before the case so combinational callers never infer a latch.
        d.legal = 1'b1;
        d.phase = 3'd0;
        case (code)
            JC_0:    d.phase = 3'd0;
            JC_1:    d.phase = 3'd1;
            JC_2:    d.phase = 3'd2;
            JC_3:    d.phase = 3'd3;
            JC_4:    d.phase = 3'd4;
            JC_5:    d.phase = 3'd5;
            JC_6:    d.phase = 3'd6;
            JC_7:    d.phase = 3'd7;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: jc_in -> phase index and legal flag.
// Stateless so other blocks watching a Johnson counter can reuse it.
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [3:0] jc_in,
    output logic [2:0] phase,
    output logic       legal
);

    jc_dec_t dec;

    // Decode the incoming code through the shared package function.
    always_comb begin
        dec = jc_to_phase(jc_in);
    end

    assign phase = dec.phase;
    assign legal = dec.legal;

endmodule

// File: rtl/johnson_monitor.sv
// Johnson-counter sequence monitor. Tracks a 4-bit Johnson code stream, locks
// onto it, counts completed 8-phase cycles and flags sequence faults.
// Optional feature: define JOHNSON_MON_ERRCNT_EN to add the err_count port
// and its saturating fault counter.
module johnson_monitor
    import johnson_pkg::*;
#(
    parameter int CYC_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       jc_in,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic             locked,
    output logic             wrap,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic             err_pulse,
    output logic             err_flag
`ifdef JOHNSON_MON_ERRCNT_EN
    ,
    output logic [ERR_W-1:0] err_count
`endif
);

    typedef logic [ERR_W-1:0] err_cnt_t;

    state_t     state;
    logic       good;        // in FAULT: last sample was legal, so the next successive code relocks
    logic [2:0] dec_phase;
    logic       dec_legal;
    logic       is_next;
    logic       is_hold;
    logic       fault_now;

    johnson_decode u_decode (
        .jc_in (jc_in),
        .phase (dec_phase),
        .legal (dec_legal)
    );

    // Classify the incoming code against the current phase.
    always_comb begin
        is_next   = dec_legal && (dec_phase == phase + 3'd1);
        is_hold   = dec_legal && (dec_phase == phase);
        fault_now = en && (state == LOCK) && !is_next && !is_hold;
    end

    // Monitor FSM with registered phase, lock, wrap, cycle and fault outputs.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state     <= HUNT;
            good      <= 1'b0;
            phase     <= 3'd0;
            locked    <= 1'b0;
            wrap      <= 1'b0;
            cycle_cnt <= '0;
            err_pulse <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            wrap      <= 1'b0;
            err_pulse <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        if (dec_legal) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                            phase  <= dec_phase;
                        end
                    end
                    LOCK: begin
                        if (is_next) begin
                            phase <= dec_phase;
                            if (phase == PHASE_LAST) begin
                                wrap      <= 1'b1;
                                cycle_cnt <= cycle_cnt + CYC_W'(1);
                            end
                        end else if (!is_hold) begin
                            state     <= FAULT;
                            locked    <= 1'b0;
                            err_pulse <= 1'b1;
                            good      <= dec_legal;
                            if (dec_legal) begin
                                phase <= dec_phase;
                            end
                        end
                    end
                    FAULT: begin
                        if (!dec_legal) begin
                            good <= 1'b0;
                        end else if (good && is_next) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                            phase  <= dec_phase;
                        end else begin
                            phase <= dec_phase;
                            good  <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase

                // A new fault wins over a simultaneous clear.
                if (fault_now) begin
                    err_flag <= 1'b1;
                end else if (clr_err) begin
                    err_flag <= 1'b0;
                end
            end
        end
    end

`ifdef JOHNSON_MON_ERRCNT_EN
    // Saturating fault counter; a fault coinciding with clr_err restarts it at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (en) begin
            if (fault_now) begin
                if (clr_err) begin
                    err_count <= err_cnt_t'(1);
                end else if (!(&err_count)) begin
                    err_count <= err_count + err_cnt_t'(1);
                end
            end else if (clr_err) begin
                err_count <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_johnson_monitor.sv
// Directed testbench for johnson_monitor with a scoreboard queue: each driven
// sample pushes its expected outputs, which are popped and compared one cycle later.
module tb_johnson_monitor;

    localparam int CYC_W = 8;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [3:0]       jc_in;
    logic             clr_err;
    logic [2:0]       phase;
    logic             locked;
    logic             wrap;
    logic [CYC_W-1:0] cycle_cnt;
    logic             err_pulse;
    logic             err_flag;
`ifdef JOHNSON_MON_ERRCNT_EN
    logic [ERR_W-1:0] err_count;
`endif

    johnson_monitor #(.CYC_W(CYC_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .jc_in     (jc_in),
        .clr_err   (clr_err),
        .phase     (phase),
        .locked    (locked),
        .wrap      (wrap),
        .cycle_cnt (cycle_cnt),
        .err_pulse (err_pulse),
        .err_flag  (err_flag)
`ifdef JOHNSON_MON_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       phase;
        logic             locked;
        logic             wrap;
        logic             err_pulse;
        logic             err_flag;
        logic [CYC_W-1:0] cyc;
        logic [ERR_W-1:0] errs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};

    // Reference model state: 0 hunting, 1 locked, 2 faulted.
    int m_st, m_ph, m_cyc, m_cnt;
    bit m_good, m_flag;
    int nw;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lookup(input logic [3:0] c);
        for (int i = 0; i < 8; i++) begin
            if (codes[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_ph = 0; m_cyc = 0; m_cnt = 0; m_good = 0; m_flag = 0;
    endtask

    task automatic model_step(input logic e, input logic [3:0] c, input logic clr);
        exp_t x;
        int   idx;
        bit   flt;
        x.wrap = 0; x.err_pulse = 0; flt = 0;
        if (e) begin
            idx = lookup(c);
            if (m_st == 0) begin
                if (idx >= 0) begin m_st = 1; m_ph = idx; end
            end else if (m_st == 1) begin
                if (idx == (m_ph + 1) % 8) begin
                    if (m_ph == 7) begin x.wrap = 1; m_cyc = (m_cyc + 1) % (1 << CYC_W); end
                    m_ph = idx;
                end else if (idx != m_ph) begin
                    flt = 1; m_st = 2; m_good = (idx >= 0);
                    if (idx >= 0) m_ph = idx;
                end
            end else begin
                if (idx < 0) m_good = 0;
                else if (m_good && idx == (m_ph + 1) % 8) begin m_st = 1; m_ph = idx; end
                else begin m_ph = idx; m_good = 1; end
            end
            if (flt) begin
                m_flag = 1; x.err_pulse = 1;
                if (clr) m_cnt = 1;
                else if (m_cnt != (1 << ERR_W) - 1) m_cnt = m_cnt + 1;
            end else if (clr) begin
                m_flag = 0; m_cnt = 0;
            end
        end
        x.phase = 3'(m_ph); x.locked = (m_st == 1); x.err_flag = m_flag;
        x.cyc = CYC_W'(m_cyc); x.errs = ERR_W'(m_cnt);
        sb.push_back(x);
    endtask

    task automatic compare_out();
        exp_t x;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
            return;
        end
        x = sb.pop_front();
        check_val("phase", 32'(phase), 32'(x.phase));
        check_val("locked", 32'(locked), 32'(x.locked));
        check_val("wrap", 32'(wrap), 32'(x.wrap));
        check_val("err_pulse", 32'(err_pulse), 32'(x.err_pulse));
        check_val("err_flag", 32'(err_flag), 32'(x.err_flag));
        check_val("cycle_cnt", 32'(cycle_cnt), 32'(x.cyc));
`ifdef JOHNSON_MON_ERRCNT_EN
        check_val("err_count", 32'(err_count), 32'(x.errs));
`endif
    endtask

    task automatic step(input logic e, input logic [3:0] c, input logic clr);
        en = e; jc_in = c; clr_err = clr;
        model_step(e, c, clr);
        @(posedge clk);
        #1;
        compare_out();
        nw += int'(wrap);
    endtask

    task automatic chk_zero(input string tag);
        check_val({tag, "_phase"}, 32'(phase), 0);
        check_val({tag, "_locked"}, 32'(locked), 0);
        check_val({tag, "_wrap"}, 32'(wrap), 0);
        check_val({tag, "_cyc"}, 32'(cycle_cnt), 0);
        check_val({tag, "_pulse"}, 32'(err_pulse), 0);
        check_val({tag, "_flag"}, 32'(err_flag), 0);
`ifdef JOHNSON_MON_ERRCNT_EN
        check_val({tag, "_errs"}, 32'(err_count), 0);
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; jc_in = 4'b0000; clr_err = 1'b0;
        model_reset();
        nw = 0;

        // Power-on reset with inputs active.
        #2 rst = 1'b0; en = 1'b1; jc_in = 4'b1000;
        #1 chk_zero("por");
        @(posedge clk); #1;
        chk_zero("por_hold");
        rst = 1'b1;

        // One full Johnson cycle: lock on first sample, single wrap, cycle_cnt=1.
        for (int i = 0; i < 9; i++) step(1'b1, codes[i % 8], 1'b0);
        check_val("cyc1_wraps", 32'(nw), 1);
        check_val("cyc1_cnt", 32'(cycle_cnt), 1);
        check_val("cyc1_phase", 32'(phase), 0);

        // Hold at phase 2 for three samples.
        step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b1100, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1100, 1'b0);
        check_val("hold_phase", 32'(phase), 2);
        check_val("hold_locked", 32'(locked), 1);
        check_val("hold_flag", 32'(err_flag), 0);

        // Fault at phase 3, illegal repeat, then recover on 1111,0111.
        step(1'b1, 4'b1110, 1'b0);
        step(1'b1, 4'b1010, 1'b0);
        check_val("flt_pulse", 32'(err_pulse), 1);
        check_val("flt_flag", 32'(err_flag), 1);
        check_val("flt_locked", 32'(locked), 0);
`ifdef JOHNSON_MON_ERRCNT_EN
        check_val("flt_errs", 32'(err_count), 1);
`endif
        step(1'b1, 4'b1010, 1'b0);
        check_val("flt_again_pulse", 32'(err_pulse), 0);
        check_val("flt_track_phase", 32'(phase), 3);
        step(1'b1, 4'b1111, 1'b0);
        check_val("rec1_locked", 32'(locked), 0);
        step(1'b1, 4'b0111, 1'b0);
        check_val("rec_locked", 32'(locked), 1);
        check_val("rec_phase", 32'(phase), 5);

        // Build up to five faults, then clear in the same cycle as a new fault.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 4'b1010, 1'b0);
            step(1'b1, 4'b0000, 1'b0);
            step(1'b1, 4'b1000, 1'b0);
        end
        check_val("five_flag", 32'(err_flag), 1);
`ifdef JOHNSON_MON_ERRCNT_EN
        check_val("five_errs", 32'(err_count), 5);
`endif
        step(1'b1, 4'b1010, 1'b1);
        check_val("clrflt_flag", 32'(err_flag), 1);
        check_val("clrflt_pulse", 32'(err_pulse), 1);
`ifdef JOHNSON_MON_ERRCNT_EN
        check_val("clrflt_errs", 32'(err_count), 1);
`endif
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1000, 1'b1);
        check_val("clr_flag", 32'(err_flag), 0);
        check_val("clr_locked", 32'(locked), 1);
        check_val("clr_phase", 32'(phase), 1);
        check_val("clr_cyc", 32'(cycle_cnt), 1);

        // Saturate the fault counter.
        for (int k = 0; k < 260; k++) begin
            step(1'b1, 4'b1010, 1'b0);
            step(1'b1, 4'b0000, 1'b0);
            step(1'b1, 4'b1000, 1'b0);
        end
`ifdef JOHNSON_MON_ERRCNT_EN
        check_val("sat_errs", 32'(err_count), 255);
`endif
        check_val("sat_flag", 32'(err_flag), 1);

        // Walk to phase 6 with cycle_cnt=3, then reset mid-run.
        for (int k = 0; k < 100 && !(m_cyc == 3 && m_ph == 6); k++) begin
            step(1'b1, codes[(m_ph + 1) % 8], 1'b0);
        end
        check_val("pre_rst_cyc", 32'(cycle_cnt), 3);
        check_val("pre_rst_phase", 32'(phase), 6);
        #2 rst = 1'b0;
        #1 chk_zero("mid_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 4'b0011, 1'b0);
        check_val("resume_locked", 32'(locked), 1);
        check_val("resume_phase", 32'(phase), 6);
        check_val("resume_pulse", 32'(err_pulse), 0);
        check_val("resume_flag", 32'(err_flag), 0);

        // 300 full cycles with a 10-clock en=0 gap in the middle.
        @(negedge clk);
        rst = 1'b0;
        #1 chk_zero("long_rst");
        model_reset();
        rst = 1'b1;
        step(1'b1, 4'b0000, 1'b0);
        nw = 0;
        for (int i = 0; i < 2400; i++) begin
            if (i == 1200) begin
                for (int j = 0; j < 10; j++) begin
                    step(1'b0, 4'($urandom_range(15)), 1'b0);
                    check_val("gap_wrap", 32'(wrap), 0);
                    check_val("gap_pulse", 32'(err_pulse), 0);
                end
            end
            step(1'b1, codes[(m_ph + 1) % 8], 1'b0);
        end
        check_val("long_wraps", 32'(nw), 300);
        check_val("long_cyc", 32'(cycle_cnt), 44);
        check_val("long_flag", 32'(err_flag), 0);
        check_val("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_monitor.md
JOHNSON_MONITOR -- requirements
Module: johnson_monitor

Interface
REQ-001 SHALL have parameter CYC_W, default 8: width of the completed-cycle counter.
REQ-002 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit: sample enable; 0 holds all state.
REQ-006 SHALL have port jc_in, input, 4 bits: 4-bit Johnson code from the upstream counter.
REQ-007 SHALL have port clr_err, input, 1 bit: synchronous clear of err_flag and err_count.
REQ-008 SHALL have port phase, output, 3 bits: decoded phase index, 0-7.
REQ-009 SHALL have port locked, output, 1 bit: FSM is in LOCK.
REQ-010 SHALL have port wrap, output, 1 bit: one-cycle pulse on a 7->0 step while locked.
REQ-011 SHALL have port cycle_cnt, output, CYC_W bits: completed cycles.
REQ-012 SHALL have port err_pulse, output, 1 bit: one-cycle pulse per detected sequence fault.
REQ-013 SHALL have port err_flag, output, 1 bit: sticky fault indicator.
REQ-014 SHALL have port err_count, output, ERR_W bits: fault count (present only under the macro; see Configuration).

Function
REQ-015 SHALL decode legal codes 0000/1000/1100/1110/1111/0111/0011/0001 to phases 0-7; the other 8 codes are illegal.
REQ-016 SHALL register all outputs; each output reflects the jc_in sampled at the previous en=1 edge (1-cycle latency).
REQ-017 SHALL, when en=0, hold the state, phase, and all counters, and drive wrap=0 and err_pulse=0.
REQ-018 SHALL implement an FSM with states HUNT, LOCK, and FAULT.
REQ-019 In HUNT: a legal code SHALL move the FSM to LOCK and load phase; an illegal code SHALL keep it in HUNT with no error raised.
REQ-020 In LOCK: a legal code equal to phase+1 mod 8 SHALL keep LOCK and update phase.
REQ-021 In LOCK: a legal code equal to the current phase (hold) SHALL keep LOCK and leave phase unchanged.
REQ-022 In LOCK: any other code SHALL move the FSM to FAULT and assert err_pulse, set err_flag, and increment err_count.
REQ-023 In FAULT: two consecutive legal, correctly successive codes SHALL return the FSM to LOCK.
REQ-024 In FAULT: an illegal code SHALL keep FAULT with no further err_pulse.
REQ-025 In FAULT: phase SHALL track the last legal code.
REQ-026 wrap SHALL assert only in LOCK on a 7->0 step; cycle_cnt SHALL increment on each wrap, modulo 2^CYC_W.
REQ-027 err_count SHALL saturate at all-ones.
REQ-028 If clr_err and a new fault occur in the same cycle, the fault SHALL win: err_flag=1 and err_count=1.
REQ-029 clr_err SHALL NOT affect the FSM, phase, or cycle_cnt.

Reset
REQ-030 rst=0 SHALL asynchronously force HUNT, phase=0, locked=0, wrap=0, cycle_cnt=0, err_pulse=0, err_flag=0, and err_count=0, including mid-operation.
REQ-031 SHALL resume sampling at the first rising edge after rst deasserts, provided en=1.

Configuration
REQ-032 Macro JOHNSON_MON_ERRCNT_EN defined: the err_count port and its saturating counter SHALL be present.
REQ-033 Macro JOHNSON_MON_ERRCNT_EN undefined: the err_count port and its counter SHALL be absent; err_pulse and err_flag SHALL be unchanged.

Structure
REQ-034 Package johnson_pkg SHALL hold the eight Johnson code constants, the FSM state enum (HUNT/LOCK/FAULT), and the code-to-phase function constants.
REQ-035 SHALL instantiate one combinational sub-module, johnson_decode (jc_in -> phase[2:0], legal), reusable by other blocks.

Verification
REQ-036 Reset, en=1, feed 0000,1000,...,0001,0000 -> locked=1 after the first sample; phase 0..7,0; wrap single pulse; cycle_cnt=1.
REQ-037 Locked at phase 3 (1110), feed 1010 -> err_pulse one cycle, err_flag=1, err_count=1, FSM in FAULT; then 1111,0111 -> locked=1, phase=5.
REQ-038 Locked at phase 2, feed 1100 three times -> phase holds at 2, no error, locked stays 1.
REQ-039 err_flag=1 and err_count=5; assert clr_err in the same cycle as a new fault -> err_flag=1, err_count=1.
REQ-040 Mid-sequence at phase 6 with cycle_cnt=3, pulse rst low -> all outputs zero immediately, FSM in HUNT; resume from code 0011 -> lock at phase 6 with no error.
REQ-041 Run 300 full cycles with CYC_W=8 -> cycle_cnt=44; with en=0 for 10 clocks mid-run -> no counter change and no pulses.
